// File: rtl/bram_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_reader_pkg
// Description : Shared types for the BRAM stream reader (controller states).
// Revision    : 1.0 - initial release
// ============================================================================
package bram_stream_reader_pkg;

    // Controller states: waiting for a command, issuing reads, emptying buffer
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage : bram_stream_reader_pkg
`default_nettype wire

// File: rtl/bram_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_reader_if
// Description : Command, BRAM read and output stream signals of the reader.
//               master = the reader block, slave = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface bram_stream_reader_if #(
    parameter int WIDTH = 10,
    parameter int AW    = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [AW-1:0]    cmd_base;
    logic [AW:0]      cmd_length;
    logic             ar_valid;
    logic [AW-1:0]    ar_address;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             o_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_last;
    logic             busy;

    modport master (
        input  cmd_valid, cmd_base, cmd_length, r_valid, r_data, o_ready,
        output cmd_ready, ar_valid, ar_address, o_valid, o_data, o_last, busy
    );

    modport slave (
        output cmd_valid, cmd_base, cmd_length, r_valid, r_data, o_ready,
        input  cmd_ready, ar_valid, ar_address, o_valid, o_data, o_last, busy
    );
endinterface : bram_stream_reader_if
`default_nettype wire

// File: rtl/bram_stream_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_reader_fifo
// Description : Synchronous FIFO; a written word is visible on the output
//               the cycle after the write. Output reads as zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_stream_reader_fifo #(
    parameter int DATA_W = 11,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_rd_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int UW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] c_PTR_LAST = PW'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [UW-1:0]     r_used;
    logic              w_push;
    logic              w_pop;

    assign o_valid   = (r_used != '0);
    assign w_push    = i_wr_en && (r_used != UW'(DEPTH));
    assign w_pop     = i_rd_en && o_valid;
    assign o_rd_data = o_valid ? r_mem[r_rd_ptr] : '0;

    // Storage array; entries are only observed after being written
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_used   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_used <= r_used + UW'(1);
                2'b01:   r_used <= r_used - UW'(1);
                default: r_used <= r_used;
            endcase
        end
    end
endmodule : bram_stream_reader_fifo
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_reader
// Description : Reads cmd_length consecutive BRAM words starting at cmd_base
//               (wrapping at DEPTH) and streams them out with a last marker.
//               Reads are credit-limited so the output FIFO cannot overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int DEPTH      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    bram_stream_reader_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_addr;
    logic [AW:0]      r_left;
    logic [CW-1:0]    r_count;
    logic             r_rd_last;

    logic             w_cmd_fire;
    logic             w_ar_valid;
    logic             w_ar_last;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_valid;
    logic [WIDTH:0]   w_fifo_word;

    assign w_cmd_fire = (r_state == ST_IDLE) && bus.cmd_valid;
    assign w_ar_last  = (r_left == (AW + 1)'(1));
    assign w_pop      = w_fifo_valid && bus.o_ready;
    // Read data is only meaningful while a command is active; stray returns
    // in IDLE (including those left over from an aborted command) are dropped.
    assign w_push     = bus.r_valid && (r_state != ST_IDLE);

    // Next-state and read-issue decode
    always_comb begin
        w_state_nxt = r_state;
        w_ar_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire && (bus.cmd_length != '0)) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (r_count < CW'(FIFO_DEPTH)) begin
                    w_ar_valid = 1'b1;
                    if (w_ar_last) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_pop && w_fifo_word[WIDTH]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Address walk, remaining-read counter, credit count and last tagging
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_left    <= '0;
            r_count   <= '0;
            r_rd_last <= 1'b0;
        end else begin
            if (w_cmd_fire) begin
                r_addr <= bus.cmd_base;
                r_left <= bus.cmd_length;
            end else if (w_ar_valid) begin
                r_addr <= (r_addr == c_LAST_ADDR) ? '0 : r_addr + AW'(1);
                r_left <= r_left - (AW + 1)'(1);
            end
            case ({w_ar_valid, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // BRAM answers exactly one cycle later, so the tag rides along
            r_rd_last <= w_ar_valid && w_ar_last;
        end
    end

    bram_stream_reader_fifo #(
        .DATA_W (WIDTH + 1),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_push),
        .i_wr_data ({r_rd_last, bus.r_data}),
        .i_rd_en   (bus.o_ready),
        .o_valid   (w_fifo_valid),
        .o_rd_data (w_fifo_word)
    );

    assign bus.cmd_ready  = (r_state == ST_IDLE);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.ar_valid   = w_ar_valid;
    assign bus.ar_address = r_addr;
    assign bus.o_valid    = w_fifo_valid;
    assign bus.o_data     = w_fifo_word[WIDTH-1:0];
    assign bus.o_last     = w_fifo_word[WIDTH];
endmodule : bram_stream_reader
`default_nettype wire
